// File: rtl/simple_cpu_control.sv
// Multi-cycle fetch/decode/execute control FSM for a small accumulator CPU.
// Define SIMPLE_CPU_ILLEGAL_TRAP_EN to send undefined opcodes to a sticky TRAP state.
module simple_cpu_control #(
  parameter int N   = 8,
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  input  logic           mem_ready,
  output logic           pc_inc,
  output logic           pc_load,
  output logic           mar_en,
  output logic           mar_sel,
  output logic           ir_en,
  output logic           acc_en,
  output logic [1:0]     alu_op,
  output logic           mem_rd,
  output logic           mem_we,
  output logic           halted,
  output logic           illegal,
  output logic [2:0]     state
);

  localparam logic [2:0] S_RST  = 3'd0;
  localparam logic [2:0] S_F1   = 3'd1;
  localparam logic [2:0] S_F2   = 3'd2;
  localparam logic [2:0] S_DEC  = 3'd3;
  localparam logic [2:0] S_EX   = 3'd4;
  localparam logic [2:0] S_HALT = 3'd5;
  localparam logic [2:0] S_TRAP = 3'd6;

  localparam logic [OPW-1:0] OP_NOP = OPW'(0);
  localparam logic [OPW-1:0] OP_LDA = OPW'(1);
  localparam logic [OPW-1:0] OP_STA = OPW'(2);
  localparam logic [OPW-1:0] OP_ADD = OPW'(3);
  localparam logic [OPW-1:0] OP_SUB = OPW'(4);
  localparam logic [OPW-1:0] OP_JMP = OPW'(5);
  localparam logic [OPW-1:0] OP_JZ  = OPW'(6);
  localparam logic [OPW-1:0] OP_HLT = OPW'(15);

  // The opcode is the top OPW bits of an N-bit instruction word.
  if (OPW > N) begin : g_bad_width
    $error("simple_cpu_control: OPW must not exceed N");
  end

  logic [2:0] state_reg;
  logic [2:0] state_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_RST;
    end else begin
      state_reg <= state_next;
    end
  end

  assign state = state_reg;

  always_comb begin
    state_next = state_reg;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    mar_en     = 1'b0;
    mar_sel    = 1'b0;
    ir_en      = 1'b0;
    acc_en     = 1'b0;
    alu_op     = 2'b00;
    mem_rd     = 1'b0;
    mem_we     = 1'b0;
    halted     = 1'b0;
    illegal    = 1'b0;
    case (state_reg)
      S_RST: state_next = S_F1;
      S_F1: begin
        mar_en     = 1'b1;
        state_next = S_F2;
      end
      S_F2: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          ir_en      = 1'b1;
          pc_inc     = 1'b1;
          state_next = S_DEC;
        end
      end
      S_DEC: begin
        case (opcode)
          OP_NOP: state_next = S_F1;
          OP_HLT: state_next = S_HALT;
          OP_JMP: begin
            pc_load    = 1'b1;
            state_next = S_F1;
          end
          OP_JZ: begin
            pc_load    = zero;
            state_next = S_F1;
          end
          OP_LDA, OP_STA, OP_ADD, OP_SUB: begin
            mar_en     = 1'b1;
            mar_sel    = 1'b1;
            state_next = S_EX;
          end
          default: begin
`ifdef SIMPLE_CPU_ILLEGAL_TRAP_EN
            state_next = S_TRAP;
`else
            state_next = S_F1;
`endif
          end
        endcase
      end
      S_EX: begin
        // IR is frozen here, so the opcode still names the instruction being executed.
        if (opcode == OP_STA) begin
          mem_we = 1'b1;
          if (mem_ready) begin
            state_next = S_F1;
          end
        end else begin
          mem_rd = 1'b1;
          if (mem_ready) begin
            acc_en     = 1'b1;
            state_next = S_F1;
            case (opcode)
              OP_ADD:  alu_op = 2'b01;
              OP_SUB:  alu_op = 2'b10;
              default: alu_op = 2'b00;
            endcase
          end
        end
      end
      S_HALT: halted = 1'b1;
      S_TRAP: begin
`ifdef SIMPLE_CPU_ILLEGAL_TRAP_EN
        illegal = 1'b1;
`endif
        state_next = S_TRAP;
      end
      default: state_next = S_RST;
    endcase
  end

endmodule

// File: tb/tb_simple_cpu_control.sv
// Self-checking bench for simple_cpu_control: directed vector table, corner sequences,
// then random instruction streams compared against an instruction-level reference model.
`timescale 1ns/1ps
module tb_simple_cpu_control;

  typedef logic [14:0] vec_t;
  // {pc_inc,pc_load,mar_en,mar_sel,ir_en,acc_en,alu_op[1:0],mem_rd,mem_we,halted,illegal,state[2:0]}
  localparam vec_t PCINC   = 15'h4000;
  localparam vec_t PCLD    = 15'h2000;
  localparam vec_t MAREN   = 15'h1000;
  localparam vec_t MARSEL  = 15'h0800;
  localparam vec_t IREN    = 15'h0400;
  localparam vec_t ACCEN   = 15'h0200;
  localparam vec_t ALU_SUB = 15'h0100;
  localparam vec_t ALU_ADD = 15'h0080;
  localparam vec_t RD      = 15'h0040;
  localparam vec_t WE      = 15'h0020;
  localparam vec_t HLT     = 15'h0010;
  localparam vec_t ILL     = 15'h0008;

`ifdef SIMPLE_CPU_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam int K_NOP = 0, K_MEM = 1, K_STO = 2, K_HLT = 3, K_JMP = 4, K_JZ = 5, K_ILL = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_inc, pc_load, mar_en, mar_sel, ir_en, acc_en, mem_rd, mem_we, halted, illegal;
  logic [1:0] alu_op;
  logic [2:0] state;

  simple_cpu_control #(.N(8), .OPW(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_inc(pc_inc), .pc_load(pc_load), .mar_en(mar_en), .mar_sel(mar_sel),
    .ir_en(ir_en), .acc_en(acc_en), .alu_op(alu_op), .mem_rd(mem_rd), .mem_we(mem_we),
    .halted(halted), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  vec_t dut_vec;
  assign dut_vec = {pc_inc, pc_load, mar_en, mar_sel, ir_en, acc_en, alu_op,
                    mem_rd, mem_we, halted, illegal, state};

  int total = 0;
  int bad   = 0;
  int kind[16];

  task automatic check(input string name, input vec_t exp);
    total++;
    if (dut_vec !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, dut_vec, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Async reset pulse; returns 1ns after the edge that enters F1.
  task automatic do_reset;
    rst = 1'b0;
    #1;
    check("reset_async", 15'h0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    tick;
  endtask

  // Reference: outputs and next state derived from the instruction class of the opcode.
  function automatic vec_t ref_out(int s, logic [3:0] op, logic z, logic r);
    vec_t v;
    v = vec_t'(s);
    case (s)
      1: v |= MAREN;
      2: begin
        v |= RD;
        if (r) v |= IREN | PCINC;
      end
      3: begin
        if (kind[op] == K_MEM || kind[op] == K_STO) v |= MAREN | MARSEL;
        if (kind[op] == K_JMP || (kind[op] == K_JZ && z)) v |= PCLD;
      end
      4: begin
        if (kind[op] == K_STO) v |= WE;
        else begin
          v |= RD;
          if (r) v |= ACCEN | ((op == 4'h3) ? ALU_ADD : (op == 4'h4) ? ALU_SUB : 15'h0);
        end
      end
      5: v |= HLT;
      6: v |= ILL;
      default: ;
    endcase
    return v;
  endfunction

  function automatic int ref_next(int s, logic [3:0] op, logic r);
    case (s)
      0: return 1;
      1: return 2;
      2: return r ? 3 : 2;
      3: begin
        if (kind[op] == K_MEM || kind[op] == K_STO) return 4;
        if (kind[op] == K_HLT) return 5;
        if (kind[op] == K_ILL) return TRAP_EN ? 6 : 1;
        return 1;
      end
      4: return r ? 1 : 4;
      default: return s;
    endcase
  endfunction

  typedef struct {
    logic [3:0] op;
    logic       z;
    logic       rdy;
    vec_t       exp;
  } vec_rec_t;
  vec_rec_t tbl[$];

  task automatic add(input logic [3:0] op, input logic z, input logic rdy, input vec_t exp);
    vec_rec_t rec;
    rec.op = op; rec.z = z; rec.rdy = rdy; rec.exp = exp;
    tbl.push_back(rec);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int ms, nxt, stuck;
    for (int i = 0; i < 16; i++) kind[i] = K_ILL;
    kind[0] = K_NOP; kind[1] = K_MEM; kind[2] = K_STO; kind[3] = K_MEM;
    kind[4] = K_MEM; kind[5] = K_JMP; kind[6] = K_JZ;  kind[15] = K_HLT;

    // NOP round trip, then LDA with waits, ADD, SUB, STA with wait, JZ taken/not, JMP.
    add(4'h0, 0, 1, 15'h0);
    add(4'h0, 0, 1, MAREN | 15'd1);
    add(4'h0, 0, 1, RD | IREN | PCINC | 15'd2);
    add(4'h0, 0, 1, 15'd3);
    add(4'h1, 0, 0, MAREN | 15'd1);
    add(4'h1, 0, 0, RD | 15'd2);
    add(4'h1, 0, 0, RD | 15'd2);
    add(4'h1, 0, 0, RD | 15'd2);
    add(4'h1, 0, 1, RD | IREN | PCINC | 15'd2);
    add(4'h1, 0, 1, MAREN | MARSEL | 15'd3);
    add(4'h1, 0, 0, RD | 15'd4);
    add(4'h1, 0, 0, RD | 15'd4);
    add(4'h1, 0, 1, RD | ACCEN | 15'd4);
    add(4'h3, 0, 1, MAREN | 15'd1);
    add(4'h3, 0, 1, RD | IREN | PCINC | 15'd2);
    add(4'h3, 0, 1, MAREN | MARSEL | 15'd3);
    add(4'h3, 0, 1, RD | ACCEN | ALU_ADD | 15'd4);
    add(4'h4, 0, 0, MAREN | 15'd1);
    add(4'h4, 0, 1, RD | IREN | PCINC | 15'd2);
    add(4'h4, 0, 0, MAREN | MARSEL | 15'd3);
    add(4'h4, 0, 1, RD | ACCEN | ALU_SUB | 15'd4);
    add(4'h2, 0, 1, MAREN | 15'd1);
    add(4'h2, 0, 1, RD | IREN | PCINC | 15'd2);
    add(4'h2, 0, 1, MAREN | MARSEL | 15'd3);
    add(4'h2, 0, 0, WE | 15'd4);
    add(4'h2, 0, 1, WE | 15'd4);
    add(4'h6, 1, 1, MAREN | 15'd1);
    add(4'h6, 1, 1, RD | IREN | PCINC | 15'd2);
    add(4'h6, 1, 0, PCLD | 15'd3);
    add(4'h6, 0, 1, MAREN | 15'd1);
    add(4'h6, 0, 1, RD | IREN | PCINC | 15'd2);
    add(4'h6, 0, 1, 15'd3);
    add(4'h5, 0, 0, MAREN | 15'd1);
    add(4'h5, 0, 1, RD | IREN | PCINC | 15'd2);
    add(4'h5, 1, 1, PCLD | 15'd3);
    add(4'h5, 0, 1, MAREN | 15'd1);

    #12;
    check("reset_initial", 15'h0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    foreach (tbl[i]) begin
      opcode = tbl[i].op; zero = tbl[i].z; mem_ready = tbl[i].rdy;
      #1;
      $display("vec %0d op=%h zero=%0d rdy=%0d state=%0d out=%h", i, opcode, zero, mem_ready, state, dut_vec);
      check($sformatf("vec%0d", i), tbl[i].exp);
      tick;
    end

    // STA interrupted by reset while mem_we is high.
    opcode = 4'h2; mem_ready = 1'b1;
    #1; check("sta_f2", RD | IREN | PCINC | 15'd2);
    tick; check("sta_dec", MAREN | MARSEL | 15'd3);
    tick; mem_ready = 1'b0;
    #1; check("sta_ex_wait", WE | 15'd4);
    tick; check("sta_ex_wait2", WE | 15'd4);
    rst = 1'b0;
    #1; check("sta_rst_async", 15'h0);
    tick; tick; check("sta_rst_hold", 15'h0);
    #2; rst = 1'b1;
    #1; check("rst_release", 15'h0);
    tick; check("rst_first_f1", MAREN | 15'd1);
    $display("seq sta_reset done");

    // HLT: sticky regardless of inputs.
    opcode = 4'hF; mem_ready = 1'b1;
    tick; tick; check("hlt_dec", 15'd3);
    tick;
    for (int i = 0; i < 20; i++) begin
      opcode = 4'($urandom); mem_ready = 1'($urandom); zero = 1'($urandom);
      #1; check("halt_hold", HLT | 15'd5);
      tick;
    end
    $display("seq halt done");
    do_reset;
    check("post_halt_f1", MAREN | 15'd1);

    // Undefined opcode 0x9.
    opcode = 4'h9; mem_ready = 1'b1;
    tick; tick; check("ill_dec", 15'd3);
    tick;
`ifdef SIMPLE_CPU_ILLEGAL_TRAP_EN
    for (int i = 0; i < 5; i++) begin
      opcode = 4'($urandom); mem_ready = 1'($urandom);
      #1; check("trap_hold", ILL | 15'd6);
      tick;
    end
`else
    check("ill_as_nop", MAREN | 15'd1);
    tick; check("ill_next_f2", RD | IREN | PCINC | 15'd2);
`endif
    $display("seq illegal done");

    // Random instruction stream against the reference model.
    do_reset;
    ms = 1; stuck = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (ms != 3 && ms != 4)
        opcode = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(0, 6));
      zero = 1'($urandom);
      mem_ready = ($urandom_range(0, 2) != 0);
      #1;
      check("rand", ref_out(ms, opcode, zero, mem_ready));
      nxt = ref_next(ms, opcode, mem_ready);
      if ((ms == 3 || ms == 4) && nxt == 1)
        $display("rand instr op=%h retired at cycle %0d", opcode, cyc);
      if (ms == 5 || ms == 6) stuck++;
      if (stuck > 3) begin
        do_reset;
        ms = 1; stuck = 0;
        continue;
      end
      tick;
      ms = nxt;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/simple_cpu_control.md
SIMPLE_CPU_CONTROL -- requirements
Module: simple_cpu_control

Interface
REQ-001 SHALL have parameter N, default 8, datapath/instruction width feeding the enabled registers.
REQ-002 SHALL have parameter OPW, default 4, opcode width; opcode is instruction bits [N-1:N-OPW].
REQ-003 SHALL have port clk  input  1  single clock, all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port opcode  input  OPW  opcode field from the instruction register output.
REQ-006 SHALL have port zero  input  1  accumulator-equals-zero flag.
REQ-007 SHALL have port mem_ready  input  1  memory completion handshake for the current mem_rd/mem_we.
REQ-008 SHALL have ports pc_inc, pc_load, mar_en, mar_sel, ir_en, acc_en  output  1 each  enables/selects for the PC, MAR, IR, ACC registers (mar_sel 0=PC, 1=IR operand).
REQ-009 SHALL have port alu_op  output  2  00 pass, 01 add, 10 sub, 11 reserved.
REQ-010 SHALL have ports mem_rd, mem_we  output  1 each  memory read/write request.
REQ-011 SHALL have ports halted, illegal  output  1 each  status; state  output  3  current state code for debug.

Function
REQ-012 SHALL implement states RST(0), F1(1), F2(2), DEC(3), EX(4), HALT(5), TRAP(6); outputs decoded from state, opcode, zero, mem_ready (no output registers).
REQ-013 SHALL drive every output 0 in every state except as listed below.
REQ-014 RST: all outputs 0; next F1 unconditionally.
REQ-015 F1: mar_en=1, mar_sel=0; next F2.
REQ-016 F2: mem_rd=1; if mem_ready then ir_en=1, pc_inc=1, next DEC; else hold F2 with mem_rd held high.
REQ-017 DEC: opcode 0x0 NOP -> F1; 0xF HLT -> HALT; 0x5 JMP -> pc_load=1, F1; 0x6 JZ -> pc_load=zero, F1; 0x1 LDA, 0x2 STA, 0x3 ADD, 0x4 SUB -> mar_en=1, mar_sel=1, EX.
REQ-018 EX for LDA/ADD/SUB: mem_rd=1; on mem_ready acc_en=1 with alu_op 00/01/10 respectively, next F1; else hold.
REQ-019 EX for STA: mem_we=1; on mem_ready next F1; else hold with mem_we high.
REQ-020 HALT: halted=1; remain until reset regardless of inputs.
REQ-021 mem_ready outside F2/EX SHALL be ignored; opcode changes in EX SHALL not occur (IR not enabled) and are not guarded.
REQ-022 Latency with mem_ready tied 1: NOP/JMP/JZ 3 cycles, LDA/STA/ADD/SUB 4 cycles, F1 to next F1.
REQ-023 pc_inc and pc_load SHALL never assert in the same cycle; ir_en and acc_en never together.

Reset
REQ-024 rst low SHALL force state to RST immediately, without waiting for clk, including mid-handshake; mem_rd/mem_we drop combinationally.
REQ-025 First rising clk after rst deasserts SHALL move RST->F1; all outputs 0 throughout reset.

Configuration
REQ-026 Macro SIMPLE_CPU_ILLEGAL_TRAP_EN: when defined, undefined opcodes (0x7-0xE) in DEC go to TRAP, which holds illegal=1 until reset.
REQ-027 Without SIMPLE_CPU_ILLEGAL_TRAP_EN, undefined opcodes behave as NOP, TRAP is unreachable, illegal is tied 0.

Verification
REQ-028 Reset release, mem_ready=1, opcode=0x0 -> state sequence 0,1,2,3,1; mar_en high in F1, ir_en+pc_inc high in F2.
REQ-029 opcode=0x1, mem_ready delayed 3 cycles in F2 and 2 in EX -> mem_rd held high throughout waits, acc_en=1 alu_op=00 for one cycle only, back to F1.
REQ-030 opcode=0x6 with zero=1 then zero=0 -> pc_load=1 in DEC first time, 0 second; both return to F1.
REQ-031 opcode=0x2, rst pulled low during EX with mem_we=1 -> mem_we=0 same instant, state=0, F1 on first clk after release.
REQ-032 opcode=0xF -> halted=1 and state=5 held for 20 cycles with random opcode/mem_ready.
REQ-033 opcode=0x9 -> with macro: state=6, illegal=1 held; without: state returns to 1, illegal=0.
